// File: rtl/bb_fifo_32x8.sv
// 32-entry x 8-bit first-word-fall-through byte FIFO with full / half-full /
// data-present flags; overflow and underflow strobes are dropped.
module bb_fifo_32x8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       write,
  input  logic       read,
  output logic [7:0] data_out,
  output logic       full,
  output logic       half_full,
  output logic       data_present
);

  logic [7:0] r_mem [0:31];
  logic [4:0] r_wr_ptr;
  logic [4:0] r_rd_ptr;
  logic [5:0] r_count;

  logic       w_full;
  logic       w_half_full;
  logic       w_data_present;
  logic       w_we;
  logic       w_re;
  logic [5:0] w_count_nxt;

  // Status decode from the registered occupancy only
  always_comb begin
    w_full         = (r_count == 6'd32);
    w_half_full    = (r_count >= 6'd16);
    w_data_present = (r_count != 6'd0);
  end

  // A write is still accepted when full as long as a read frees a slot in the same cycle
  always_comb begin
    w_we = write & (~w_full | read);
    w_re = read & w_data_present;
  end

  // Occupancy update
  always_comb begin
    w_count_nxt = r_count;
    case ({w_we, w_re})
      2'b10:   w_count_nxt = r_count + 6'd1;
      2'b01:   w_count_nxt = r_count - 6'd1;
      2'b11:   w_count_nxt = r_count;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 5'd0;
      r_rd_ptr <= 5'd0;
      r_count  <= 6'd0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 5'd1;
      end
      if (w_re) begin
        r_rd_ptr <= r_rd_ptr + 5'd1;
      end
      r_count <= w_count_nxt;
    end
  end

  // Output drive
  always_comb begin
    data_out     = r_mem[r_rd_ptr];
    full         = w_full;
    half_full    = w_half_full;
    data_present = w_data_present;
  end

endmodule

// File: tb/tb_bb_fifo_32x8.sv
// Directed self-checking bench for bb_fifo_32x8: reset, FWFT ordering, flag
// thresholds, overflow drop, simultaneous read/write and mid-stream reset.
module tb_bb_fifo_32x8;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       write;
  logic       read;
  logic [7:0] data_out;
  logic       full;
  logic       half_full;
  logic       data_present;

  int n_vec;
  int n_err;

  bb_fifo_32x8 dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .write        (write),
    .read         (read),
    .data_out     (data_out),
    .full         (full),
    .half_full    (half_full),
    .data_present (data_present)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seq_byte(input int i);
    seq_byte = 8'((i % 17) + 1);
  endfunction

  task automatic wr(input logic [7:0] d);
    data_in = d;
    write   = 1'b1;
    @(posedge clk);
    #1;
    write   = 1'b0;
  endtask

  task automatic rd();
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] f;
    reset = 1'b0; write = 1'b1; read = 1'b0; data_in = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL reset_hold flags=%b expected=000", f);
    end
    write = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release flags=%b expected=000", f);
    end
  endtask

  task automatic test_single();
    logic [2:0] f;
    wr(8'h01);
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b001) begin
      n_err++;
      $display("FAIL single_flags flags=%b expected=001", f);
    end
    n_vec++;
    if (data_out !== 8'h01) begin
      n_err++;
      $display("FAIL single_data data_out=%h expected=01", data_out);
    end
    rd();
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL single_empty flags=%b expected=000", f);
    end
  endtask

  task automatic test_half_full();
    logic [2:0] f;
    for (int i = 0; i < 17; i++) begin
      wr(seq_byte(i));
      @(posedge clk);
      #1;
      if (i == 14 || i == 15) begin
        f = {full, half_full, data_present};
        n_vec++;
        if (f !== ((i == 15) ? 3'b011 : 3'b001)) begin
          n_err++;
          $display("FAIL half_full_at_%0d flags=%b expected=%b", i + 1, f,
                   (i == 15) ? 3'b011 : 3'b001);
        end
      end
    end
    for (int i = 0; i < 17; i++) begin
      n_vec++;
      if (data_out !== seq_byte(i)) begin
        n_err++;
        $display("FAIL order_%0d data_out=%h expected=%h", i, data_out, seq_byte(i));
      end
      rd();
    end
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL order_empty flags=%b expected=000", f);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] f;
    for (int i = 0; i < 34; i++) begin
      wr(seq_byte(i));
      if (i == 30 || i == 31) begin
        f = {full, half_full, data_present};
        n_vec++;
        if (f !== ((i == 31) ? 3'b111 : 3'b011)) begin
          n_err++;
          $display("FAIL full_at_%0d flags=%b expected=%b", i + 1, f,
                   (i == 31) ? 3'b111 : 3'b011);
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (data_out !== seq_byte(i)) begin
        n_err++;
        $display("FAIL ovf_order_%0d data_out=%h expected=%h", i, data_out, seq_byte(i));
      end
      rd();
    end
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL ovf_empty flags=%b expected=000", f);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] f;
    for (int i = 0; i < 32; i++) wr(seq_byte(i));
    data_in = 8'hAA; write = 1'b1; read = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b111) begin
      n_err++;
      $display("FAIL rw_full_flags flags=%b expected=111", f);
    end
    for (int i = 1; i < 33; i++) begin
      n_vec++;
      if (data_out !== ((i == 32) ? 8'hAA : seq_byte(i))) begin
        n_err++;
        $display("FAIL rw_full_order_%0d data_out=%h expected=%h", i, data_out,
                 (i == 32) ? 8'hAA : seq_byte(i));
      end
      rd();
    end
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL rw_full_drain flags=%b expected=000", f);
    end
    data_in = 8'h55; write = 1'b1; read = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b001 || data_out !== 8'h55) begin
      n_err++;
      $display("FAIL rw_empty flags=%b data_out=%h expected=001/55", f, data_out);
    end
    rd();
  endtask

  task automatic test_underflow_reset();
    logic [2:0] f;
    rd();
    rd();
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL underflow flags=%b expected=000", f);
    end
    wr(8'h33);
    n_vec++;
    if (data_out !== 8'h33 || data_present !== 1'b1) begin
      n_err++;
      $display("FAIL after_underflow data_out=%h dp=%b expected=33/1", data_out, data_present);
    end
    for (int i = 0; i < 9; i++) wr(8'(8'hC0 + i));
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b001) begin
      n_err++;
      $display("FAIL ten_stored flags=%b expected=001", f);
    end
    #2;
    reset = 1'b0;
    #1;
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset flags=%b expected=000", f);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr(8'h77);
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b001 || data_out !== 8'h77) begin
      n_err++;
      $display("FAIL post_reset_write flags=%b data_out=%h expected=001/77", f, data_out);
    end
    rd();
    f = {full, half_full, data_present};
    n_vec++;
    if (f !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_drain flags=%b expected=000", f);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_half_full();
    test_overflow();
    test_simultaneous();
    test_underflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
